// File: rtl/onchip_mem_arbiter.sv
// Purpose : two-master Avalon-MM arbiter in front of a single-port on-chip RAM.
// Latency : grant is combinational in the request cycle; read data returns 1 cycle after accept.
// Backpressure: the losing or idle master sees waitrequest=1 and must hold its request; nothing is latched here.
//
// Ports
//   clk, reset            system clock; synchronous active-high reset
//   m0_* / m1_*           Avalon-MM slave ports (m0 = CPU data master, m1 = capture/display DMA)
//                         address, byteenable, read, write, writedata in; waitrequest, readdata,
//                         readdatavalid out
//   mem_*                 drive to the RAM (address, byteenable, chipselect, write, writedata,
//                         clken) and its unregistered q (mem_readdata)
//
// Build option: define ONCHIP_ARB_FIXED_PRIO_EN to give m0 absolute priority on ties
// (m1 may then starve). Default build is round-robin on ties.

module onchip_mem_arbiter #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  localparam int BE_W = DATA_W / 8;

  // One master's request bundled so the winner mux is a single select.
  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } mem_req_t;

  logic     req0;
  logic     req1;
  logic     gnt0;
  logic     gnt1;
  logic     gnt_any;
  mem_req_t m0_req;
  mem_req_t m1_req;
  mem_req_t win_req;

  logic              rd_pend;   // a read was accepted at the last edge
  logic              rd_owner;  // 0 = m0, 1 = m1
  logic [ADDR_W-1:0] addr_q;    // last issued address, held on idle cycles

  // A simultaneous read+write is a write: the write flag alone decides the access type.
  always_comb begin
    m0_req = '{address: m0_address, byteenable: m0_byteenable,
               write: m0_write, writedata: m0_writedata};
    m1_req = '{address: m1_address, byteenable: m1_byteenable,
               write: m1_write, writedata: m1_writedata};
  end

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

`ifdef ONCHIP_ARB_FIXED_PRIO_EN

  // m0 always wins a tie; no history is needed.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      gnt0 = req0;
      gnt1 = req1 & ~req0;
    end
  end

`else

  logic last_grant;  // 0 = m0 won last, 1 = m1 won last

  // Round-robin: on a tie the master that did not win last time goes next,
  // so each requester is served within two cycles.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt0 = last_grant;
        gnt1 = ~last_grant;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // Reset to "m1 won last" so the first tie after reset goes to m0.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1;
    end
  end

`endif

  assign gnt_any = gnt0 | gnt1;
  assign win_req = gnt1 ? m1_req : m0_req;

  assign m0_waitrequest = ~gnt0;
  assign m1_waitrequest = ~gnt1;

  // RAM drive. Byte lanes only matter on writes; reads fetch the full word.
  assign mem_chipselect = gnt_any;
  assign mem_write      = gnt_any & win_req.write;
  assign mem_address    = gnt_any ? win_req.address : addr_q;
  assign mem_byteenable = (gnt_any && win_req.write) ? win_req.byteenable : {BE_W{1'b1}};
  assign mem_writedata  = win_req.writedata;
  assign mem_clken      = 1'b1;

  // Address hold register is pure datapath; reset leaves it alone.
  always_ff @(posedge clk) begin
    if (gnt_any) begin
      addr_q <= win_req.address;
    end
  end

  // Read return tracking. Only reads set rd_pend; writes complete at the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= gnt_any & ~win_req.write;
      if (gnt_any) begin
        rd_owner <= gnt1;
      end
    end
  end

  // RAM q goes to both ports; only the owner sees valid. Reset in the return
  // cycle kills the pulse combinationally.
  assign m0_readdata      = mem_readdata;
  assign m1_readdata      = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~rd_owner & ~reset;
  assign m1_readdatavalid = rd_pend &  rd_owner & ~reset;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Purpose : self-checking bench for onchip_mem_arbiter with a behavioural RAM and reference model.
// Latency : inputs change just after negedge; outputs sampled 1 time unit later.
// Backpressure: bench masters hold their request while waitrequest is high.

module tb_onchip_mem_arbiter;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int DEPTH  = 8192;

  logic              clk = 1'b0;
  logic              reset;

  logic [ADDR_W-1:0] m_address   [2];
  logic [BE_W-1:0]   m_byteenable[2];
  logic              m_read      [2];
  logic              m_write     [2];
  logic [DATA_W-1:0] m_writedata [2];

  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata, mem_readdata;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m_address[0]),
    .m0_byteenable    (m_byteenable[0]),
    .m0_read          (m_read[0]),
    .m0_write         (m_write[0]),
    .m0_writedata     (m_writedata[0]),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m_address[1]),
    .m1_byteenable    (m_byteenable[1]),
    .m1_read          (m_read[1]),
    .m1_write         (m_write[1]),
    .m1_writedata     (m_writedata[1]),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_writedata    (mem_writedata),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // RAM stand-in: registered address, unregistered q.
  logic [31:0]       ram [DEPTH];
  logic [ADDR_W-1:0] ram_rd_addr = '0;
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
      else           ram_rd_addr <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_rd_addr];

  // Reference model state: who won last, what memory holds, what return is due.
  logic [31:0]       ref_mem [DEPTH];
  int                ref_last  = 1;
  bit                ref_pend  = 0;
  int                ref_owner = 0;
  logic [31:0]       ref_data  = '0;
  bit                hold_known = 0;
  logic [ADDR_W-1:0] hold_addr = '0;

  int checks = 0;
  int errors = 0;

  // Values sampled in the most recent cycle, for directed checks.
  logic        s_w [2];
  logic        s_rv[2];
  logic [31:0] s_rd[2];
  logic        s_mw;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_idle(input int n);
    m_read[n]       = 1'b0;
    m_write[n]      = 1'b0;
    m_address[n]    = '0;
    m_byteenable[n] = '0;
    m_writedata[n]  = '0;
  endtask

  task automatic set_req(input int n, input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
    m_read[n]       = rd;
    m_write[n]      = wr;
    m_address[n]    = a;
    m_writedata[n]  = d;
    m_byteenable[n] = be;
  endtask

  // One clock: inputs are already set (just after negedge). Predict, compare, advance model.
  task automatic cycle();
    int                win;
    bit                r0, r1, wr;
    logic [ADDR_W-1:0] a;
    logic [3:0]        be;
    logic [31:0]       wd;
    #1;
    r0  = m_read[0] | m_write[0];
    r1  = m_read[1] | m_write[1];
    win = -1;
    if (!reset) begin
      if (r0 && r1) begin
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
        win = 0;
`else
        win = (ref_last == 1) ? 0 : 1;
`endif
      end else if (r0) win = 0;
      else if (r1) win = 1;
    end
    if (win == 1) begin
      wr = m_write[1]; a = m_address[1]; be = m_byteenable[1]; wd = m_writedata[1];
    end else begin
      wr = m_write[0]; a = m_address[0]; be = m_byteenable[0]; wd = m_writedata[0];
    end

    s_w[0] = m0_waitrequest;    s_w[1] = m1_waitrequest;
    s_rv[0] = m0_readdatavalid; s_rv[1] = m1_readdatavalid;
    s_rd[0] = m0_readdata;      s_rd[1] = m1_readdata;
    s_mw = mem_write;

    check("m0_waitrequest", 32'(m0_waitrequest), 32'(win != 0));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'(win != 1));
    check("mem_chipselect", 32'(mem_chipselect), 32'(win >= 0));
    check("mem_write", 32'(mem_write), 32'(win >= 0 && wr));
    if (win >= 0) begin
      check("mem_address", 32'(mem_address), 32'(a));
      check("mem_byteenable", 32'(mem_byteenable), wr ? 32'(be) : 32'hF);
      if (wr) check("mem_writedata", mem_writedata, wd);
    end else if (hold_known) begin
      check("mem_address_hold", 32'(mem_address), 32'(hold_addr));
    end
    check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(ref_pend && ref_owner == 0 && !reset));
    check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(ref_pend && ref_owner == 1 && !reset));
    if (ref_pend && !reset) begin
      check("m0_readdata", m0_readdata, ref_data);
      check("m1_readdata", m1_readdata, ref_data);
    end

    @(posedge clk);
    if (reset) begin
      ref_last = 1;
      ref_pend = 0;
    end else begin
      ref_pend = 0;
      if (win >= 0) begin
        ref_last   = win;
        hold_addr  = a;
        hold_known = 1;
        if (wr) ref_mem[a] = merge(ref_mem[a], wd, be);
        else begin
          ref_pend  = 1;
          ref_owner = win;
          ref_data  = ref_mem[a];
        end
      end
    end
    @(negedge clk);
  endtask

  // Pick a fresh random request for master n (idle ~40% of the time).
  task automatic rand_req(input int n);
    int kind;
    kind = $urandom_range(0, 9);
    if (kind < 4) set_idle(n);
    else set_req(n, kind != 7, kind >= 7, ADDR_W'($urandom_range(0, 31)),
                 $urandom, 4'($urandom_range(0, 15)));
  endtask

  initial begin
    logic [31:0] pre_hi;
    logic [7:0]  g0, g1;
    int          rv0_cnt, rv1_cnt;

    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[5]     = 32'hDEADBEEF;
    ref_mem[5] = 32'hDEADBEEF;
    pre_hi     = ref_mem[13'h1FFF];

    // Reset with both masters requesting: nothing may be granted.
    reset = 1'b1;
    set_req(0, 1, 0, 13'h0001, 0, 4'hF);
    set_req(1, 1, 0, 13'h0002, 0, 4'hF);
    @(negedge clk);
    cycle();
    check("rst_m0_waitrequest", 32'(s_w[0]), 32'd1);
    check("rst_m1_waitrequest", 32'(s_w[1]), 32'd1);
    cycle();
    reset = 1'b0;
    set_idle(0);
    set_idle(1);
    cycle();

    // m0 read of the preloaded word.
    set_req(0, 1, 0, 13'h0005, 0, 4'h0);
    cycle();
    check("rd5_accept", 32'(s_w[0]), 32'd0);
    set_idle(0);
    cycle();
    check("rd5_valid_m0", 32'(s_rv[0]), 32'd1);
    check("rd5_data", s_rd[0], 32'hDEADBEEF);
    check("rd5_valid_m1", 32'(s_rv[1]), 32'd0);

    // m1 partial write then immediate read-back, no bubble.
    set_req(1, 0, 1, 13'h1FFF, 32'h12345678, 4'b0011);
    cycle();
    check("wr1fff_accept", 32'(s_w[1]), 32'd0);
    set_req(1, 1, 0, 13'h1FFF, 0, 4'h0);
    cycle();
    check("rd1fff_accept", 32'(s_w[1]), 32'd0);
    set_idle(1);
    cycle();
    check("rd1fff_valid", 32'(s_rv[1]), 32'd1);
    check("rd1fff_data", s_rd[1], {pre_hi[31:16], 16'h5678});

    // Both masters read continuously for 8 cycles.
    g0 = '0; g1 = '0; rv0_cnt = 0; rv1_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 1, 0, 13'h0100, 0, 4'h0);
      set_req(1, 1, 0, 13'h0200, 0, 4'h0);
      cycle();
      g0[i] = ~s_w[0];
      g1[i] = ~s_w[1];
      if (i > 0) begin
        rv0_cnt += int'(s_rv[0]);
        rv1_cnt += int'(s_rv[1]);
      end
    end
    set_idle(0);
    cycle();
    check("m1_after_m0_drops", 32'(s_w[1]), 32'd0);
    rv0_cnt += int'(s_rv[0]);
    rv1_cnt += int'(s_rv[1]);
    set_idle(1);
    cycle();
`ifdef ONCHIP_ARB_FIXED_PRIO_EN
    check("tie_grants_m0", 32'(g0), 32'h000000FF);
    check("tie_grants_m1", 32'(g1), 32'h00000000);
    check("tie_rv_m0", 32'(rv0_cnt), 32'd8);
    check("tie_rv_m1", 32'(rv1_cnt), 32'd0);
`else
    check("tie_grants_m0", 32'(g0), 32'h00000055);
    check("tie_grants_m1", 32'(g1), 32'h000000AA);
    check("tie_rv_m0", 32'(rv0_cnt), 32'd4);
    check("tie_rv_m1", 32'(rv1_cnt), 32'd4);
`endif

    // Reset in the return cycle of an accepted read.
    set_req(0, 1, 0, 13'h0007, 0, 4'h0);
    cycle();
    check("midrst_accept", 32'(s_w[0]), 32'd0);
    reset = 1'b1;
    set_req(1, 1, 0, 13'h0008, 0, 4'h0);
    cycle();
    check("midrst_no_valid", 32'(s_rv[0]), 32'd0);
    reset = 1'b0;
    cycle();
    check("postrst_tie_m0", 32'(s_w[0]), 32'd0);
    check("postrst_tie_m1_wait", 32'(s_w[1]), 32'd1);
    set_idle(0);
    set_idle(1);
    cycle();

    // Read and write together is a write.
    set_req(1, 1, 1, 13'h0010, 32'hCAFEF00D, 4'hF);
    cycle();
    check("rdwr_is_write", 32'(s_mw), 32'd1);
    set_idle(1);
    cycle();
    check("rdwr_no_valid", 32'(s_rv[1]), 32'd0);
    set_req(0, 1, 0, 13'h0010, 0, 4'h0);
    cycle();
    set_idle(0);
    cycle();
    check("rdwr_readback_valid", 32'(s_rv[0]), 32'd1);
    check("rdwr_readback_data", s_rd[0], 32'hCAFEF00D);

    // Random traffic; stalled masters hold their request.
    rand_req(0);
    rand_req(1);
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      cycle();
      if (!s_w[0] || !(m_read[0] || m_write[0])) rand_req(0);
      if (!s_w[1] || !(m_read[1] || m_write[1])) rand_req(1);
    end
    reset = 1'b0;
    set_idle(0);
    set_idle(1);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
